mult_div_unit: RTL
==================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, serving the MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO paths of the multicycle CPU datapath. It accepts a one-cycle start pulse from the control FSM and iterates one bit per cycle, shift-add for multiply and restoring division for divide. It reports completion with a one-cycle `done` pulse and flags divide-by-zero for the exception path. Operand width is generic so the same block serves the 32-bit core and narrower test configurations.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand or dividend (RegA).
- b  in  WIDTH  multiplier or divisor (RegB).
- hi_we  in  1  load `wdata` into HI (MTHI).
- lo_we  in  1  load `wdata` into LO (MTLO).
- wdata  in  WIDTH  data for MTHI/MTLO.
- hi  out  WIDTH  HI register: upper product half, or remainder.
- lo  out  WIDTH  LO register: lower product half, or quotient.
- busy  out  1  high while in CALC or FIX.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with `done`, for DIV/DIVU with b==0.

## Operation
- FSM states: IDLE, CALC, FIX.
- **Launch (IDLE, start=1, non-zero divide or any multiply):**
  - Capture magnitudes of a and b; take absolute values for signed ops.
  - Capture the result signs and the op.
  - Clear the accumulator, load the iteration counter with WIDTH, and go to CALC.
- **CALC:** one iteration per cycle; the counter decrements; on reaching 0, go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits internally.
- **FIX:**
  - Apply sign correction.
  - Write HI/LO, pulse `done`, and return to IDLE.
- **Arithmetic rules:**
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV with most-negative / -1: lo = most-negative value (wraps), hi = 0; no flag.
- **Divide by zero (DIV/DIVU, b==0, sampled at start):**
  - Go directly to IDLE; do not enter CALC.
  - Assert `done` and `div_zero` for one cycle after the start edge.
  - HI and LO are unchanged.
- `start` while busy: ignored; the operation in progress is unaffected.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored while busy.
  - If start and a write arrive on the same IDLE edge, the write takes effect and the operation launches with the captured a/b.
  - The final FIX write later overwrites HI/LO.
- HI/LO change only on FIX, on hi_we/lo_we, or on reset.
- **Reset (rst=0, any time):**
  - State goes to IDLE; hi=lo=0; busy=done=div_zero=0.
  - An operation in progress is aborted with no `done`.

## Timing
- Start sampled at edge E0.
- busy is high from after E0 through the cycle ending at edge E0+WIDTH+1.
- HI/LO are updated and `done`=1 after edge E0+WIDTH+1, i.e. latency WIDTH+1 cycles (33 for WIDTH=32).
- `done` is high for exactly one cycle; busy is already 0 in that cycle, so a new start may be issued in the `done` cycle.
- Divide-by-zero latency is 1 cycle: `done`/`div_zero` are high after E0, and busy never rises.
- hi/lo/busy/done/div_zero are all registered outputs; there is no combinational path from any input to any output.

## Configuration
- `MULT_DIV_SIGNED_EN` defined:
  - Signed MULT/DIV are supported as described above.
  - Adds the magnitude and negation logic in launch/FIX.
- `MULT_DIV_SIGNED_EN` undefined:
  - op[0] is ignored and all ops execute as unsigned (MULTU/DIVU).
  - FIX performs no sign correction; latency is unchanged.

## Test plan
- MULT, WIDTH=32, a=-3, b=5 -> after 33 cycles: hi=FFFFFFFF, lo=FFFFFFF1, `done` pulse of 1 cycle, busy high for 33 cycles.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- MTHI 12345678, then DIV with b=0 -> `done`=`div_zero`=1 one cycle after start, busy never high, hi=12345678 unchanged.
- Second start and hi_we mid-CALC of MULTU FFFFFFFF*FFFFFFFF -> both ignored; hi=FFFFFFFE, lo=00000001 at cycle 33.
- rst low at cycle 10 of a DIV -> hi=lo=0 and busy=0 immediately; no `done`; a fresh MULTU 6*7 then gives lo=42, hi=0.
- Build without the macro: MULT a=-1 (FFFFFFFF), b=2 -> hi=00000001, lo=FFFFFFFE (unsigned result).

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide; done pulses WIDTH+1
// cycles after start. Divide by zero completes in one cycle with div_zero set.
// Optional macro MULT_DIV_SIGNED_EN enables signed MULT/DIV; without it op[0]
// is ignored and every operation runs unsigned.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   opnd_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic               div_by_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign div_by_zero = op_i[1] & (b_i == '0);

`ifdef MULT_DIV_SIGNED_EN
  logic neg_res_q;
  logic neg_rem_q;
  logic signed_op;
  logic a_neg;
  logic b_neg;

  // Signed ops iterate on magnitudes; the signs are re-applied in FIX.
  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
`else
  logic op0_unused;

  // op[0] is deliberately dropped: every operation runs unsigned.
  assign op0_unused = op_i[0];
  assign a_mag      = a_i;
  assign b_mag      = b_i;
`endif

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Final HI/LO values, with sign correction when signed ops are built in.
  always_comb begin
    fix_hi = acc_q[2*WIDTH-1:WIDTH];
    fix_lo = acc_q[WIDTH-1:0];
`ifdef MULT_DIV_SIGNED_EN
    if (!is_div_q) begin
      if (neg_res_q) begin
        {fix_hi, fix_lo} = -acc_q;
      end
    end else begin
      if (neg_res_q) begin
        fix_lo = -acc_q[WIDTH-1:0];
      end
      if (neg_rem_q) begin
        fix_hi = -acc_q[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  // Control FSM plus datapath and HI/LO registers, all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            if (div_by_zero) begin
              // Completes immediately; HI/LO keep their value.
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end else begin
              is_div_q <= op_i[1];
              cnt_q    <= CW'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= CALC;
              if (op_i[1]) begin
                opnd_q <= b_mag;
                acc_q  <= {{WIDTH{1'b0}}, a_mag};
              end else begin
                opnd_q <= a_mag;
                acc_q  <= {{WIDTH{1'b0}}, b_mag};
              end
`ifdef MULT_DIV_SIGNED_EN
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
`endif
            end
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;

endmodule
